// File: rtl/conv_window_if.sv
// Pixel-stream in / 3x3 window out bundle for conv_window.
// The slave modport is the window generator's view; the master is the producer's view.
interface conv_window_if #(
   parameter int N       = 8,
   parameter int CHANNEL = 3
);
   logic                     clr;
   logic                     din_vld;
   logic [CHANNEL*N-1:0]     din;
   logic [9*CHANNEL*N-1:0]   win_dout;
   logic                     win_vld;
   logic                     win_end;

   modport slave (
      input  clr, din_vld, din,
      output win_dout, win_vld, win_end
   );

   modport master (
      output clr, din_vld, din,
      input  win_dout, win_vld, win_end
   );
endinterface

// File: rtl/conv_window.sv
// 3x3 sliding-window generator over a raster SIZE x SIZE frame using two line buffers.
// Windows are emitted one cycle after the pixel that completes them; partial windows are suppressed.
module conv_window #(
   parameter int N       = 8,
   parameter int CHANNEL = 3,
   parameter int SIZE    = 34
) (
   input  logic          clk,
   input  logic          rst,
   conv_window_if.slave  bus
);
   localparam int PW = CHANNEL * N;
   localparam int CW = $clog2(SIZE);

   logic [CW-1:0]   r_row;
   logic [CW-1:0]   r_col;
   logic [PW-1:0]   r_line1 [SIZE];
   logic [PW-1:0]   r_line2 [SIZE];
   logic [PW-1:0]   r_win   [3][3];
   logic [9*PW-1:0] r_dout;
   logic            r_vld;
   logic            r_end;

   logic            w_accept;
   logic            w_col_last;
   logic            w_row_last;
   logic            w_win_ok;
   logic [PW-1:0]   w_new [3];
   logic [9*PW-1:0] w_next;

   assign w_accept   = bus.din_vld & ~bus.clr & ~rst;
   assign w_col_last = (r_col == CW'(SIZE - 1));
   assign w_row_last = (r_row == CW'(SIZE - 1));
   assign w_win_ok   = (r_row >= CW'(2)) && (r_col >= CW'(2));

   // Row 0 of the window is the oldest row, taken from the two-row delay.
   assign w_new[0] = r_line2[r_col];
   assign w_new[1] = r_line1[r_col];
   assign w_new[2] = bus.din;

   always_comb begin
      w_next = '0;
      for (int r = 0; r < 3; r++) begin
         w_next[(3*r)*PW   +: PW] = r_win[r][1];
         w_next[(3*r+1)*PW +: PW] = r_win[r][2];
         w_next[(3*r+2)*PW +: PW] = w_new[r];
      end
   end

   // Pixel storage is deliberately left out of reset and clr; the row/col gate keeps stale data out.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_line1[r_col] <= bus.din;
         r_line2[r_col] <= r_line1[r_col];
         for (int r = 0; r < 3; r++) begin
            r_win[r][0] <= r_win[r][1];
            r_win[r][1] <= r_win[r][2];
            r_win[r][2] <= w_new[r];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_row  <= '0;
         r_col  <= '0;
         r_vld  <= 1'b0;
         r_end  <= 1'b0;
         r_dout <= '0;
      end else if (bus.clr) begin
         r_row  <= '0;
         r_col  <= '0;
         r_vld  <= 1'b0;
         r_end  <= 1'b0;
      end else if (bus.din_vld) begin
         r_vld <= w_win_ok;
         r_end <= w_row_last && w_col_last;
         if (w_win_ok) begin
            r_dout <= w_next;
         end
         if (w_col_last) begin
            r_col <= '0;
            r_row <= w_row_last ? '0 : r_row + CW'(1);
         end else begin
            r_col <= r_col + CW'(1);
         end
      end else begin
         r_vld <= 1'b0;
         r_end <= 1'b0;
      end
   end

   assign bus.win_dout = r_dout;
   assign bus.win_vld  = r_vld;
   assign bus.win_end  = r_end;
endmodule

// File: tb/tb_conv_window.sv
// Directed bench for conv_window: a 4x4 single-channel instance and a default 34x34 instance.
module tb_conv_window;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   conv_window_if #(.N(8), .CHANNEL(1)) bus_a ();
   conv_window_if #(.N(8), .CHANNEL(3)) bus_b ();

   conv_window #(.N(8), .CHANNEL(1), .SIZE(4)) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a.slave)
   );
   conv_window #(.N(8), .CHANNEL(3), .SIZE(34)) dut_b (
      .clk(clk), .rst(rst), .bus(bus_b.slave)
   );

   typedef struct {
      logic [7:0]  din;
      logic        vld;
      logic        fin;
      logic [71:0] win;
   } vec_t;

   vec_t        tbl [16];
   int          n_err = 0;
   int          n_chk = 0;

   int          mr, mc, n_win, n_end;
   logic [7:0]  img [4][4];
   logic [71:0] m_dout;
   logic        e_vld, e_end;

   logic [23:0]  imgb [34][34];
   logic [215:0] bw;

   function automatic logic [71:0] pack9(input logic [7:0] a0, a1, a2, a3, a4,
                                          a5, a6, a7, a8);
      return {a8, a7, a6, a5, a4, a3, a2, a1, a0};
   endfunction

   task automatic chk(input string name, input logic [215:0] act, input logic [215:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_a(input logic v, input logic [7:0] d, input logic c);
      @(negedge clk);
      bus_a.din_vld = v;
      bus_a.din     = d;
      bus_a.clr     = c;
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle on the small instance and compare against the frame-image model.
   task automatic step_a(input string tag, input logic v, input logic [7:0] d, input logic c);
      drive_a(v, d, c);
      e_vld = 1'b0;
      e_end = 1'b0;
      if (c) begin
         mr = 0;
         mc = 0;
      end else if (v) begin
         img[mr][mc] = d;
         e_vld = (mr >= 2) && (mc >= 2);
         e_end = (mr == 3) && (mc == 3);
         if (e_vld)
            for (int r = 0; r < 3; r++)
               for (int k = 0; k < 3; k++)
                  m_dout[(3*r+k)*8 +: 8] = img[mr-2+r][mc-2+k];
         if (mc == 3) begin
            mc = 0;
            mr = (mr == 3) ? 0 : mr + 1;
         end else begin
            mc = mc + 1;
         end
      end
      chk({tag, " vld"}, 216'(bus_a.win_vld), 216'(e_vld));
      chk({tag, " end"}, 216'(bus_a.win_end), 216'(e_end));
      chk({tag, " dout"}, 216'(bus_a.win_dout), 216'(m_dout));
      if (bus_a.win_vld) n_win++;
      if (bus_a.win_end) n_end++;
   endtask

   initial begin
      bus_a.clr = 1'b0; bus_a.din_vld = 1'b0; bus_a.din = '0;
      bus_b.clr = 1'b0; bus_b.din_vld = 1'b0; bus_b.din = '0;

      for (int i = 0; i < 16; i++) begin
         tbl[i].din = 8'(i + 1);
         tbl[i].vld = 1'b0;
         tbl[i].fin = 1'b0;
         tbl[i].win = '0;
      end
      tbl[10].vld = 1'b1; tbl[10].win = pack9(1, 2, 3, 5, 6, 7, 9, 10, 11);
      tbl[11].vld = 1'b1; tbl[11].win = pack9(2, 3, 4, 6, 7, 8, 10, 11, 12);
      tbl[12].win = tbl[11].win;
      tbl[13].win = tbl[11].win;
      tbl[14].vld = 1'b1; tbl[14].win = pack9(5, 6, 7, 9, 10, 11, 13, 14, 15);
      tbl[15].vld = 1'b1; tbl[15].win = pack9(6, 7, 8, 10, 11, 12, 14, 15, 16);
      tbl[15].fin = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst vld", 216'(bus_a.win_vld), 216'(0));
      chk("rst end", 216'(bus_a.win_end), 216'(0));
      chk("rst dout", 216'(bus_a.win_dout), 216'(0));
      @(negedge clk);
      rst = 1'b0;

      // Basic 4x4 frame from the vector table
      for (int i = 0; i < 16; i++) begin
         drive_a(1'b1, tbl[i].din, 1'b0);
         chk($sformatf("tbl[%0d] vld", i), 216'(bus_a.win_vld), 216'(tbl[i].vld));
         chk($sformatf("tbl[%0d] end", i), 216'(bus_a.win_end), 216'(tbl[i].fin));
         chk($sformatf("tbl[%0d] dout", i), 216'(bus_a.win_dout), 216'(tbl[i].win));
      end
      mr = 0; mc = 0; m_dout = tbl[15].win;
      step_a("idle", 1'b0, 8'd0, 1'b0);

      // Same frame with random gaps
      n_win = 0; n_end = 0;
      for (int i = 1; i <= 16; i++) begin
         int g;
         g = $urandom_range(0, 5);
         for (int k = 0; k < g; k++) step_a("gap idle", 1'b0, 8'd0, 1'b0);
         step_a("gap pix", 1'b1, 8'(i), 1'b0);
      end
      step_a("gap tail", 1'b0, 8'd0, 1'b0);
      chk("gap nwin", 216'(n_win), 216'(4));
      chk("gap nend", 216'(n_end), 216'(1));

      // Two frames back to back
      n_win = 0; n_end = 0;
      for (int i = 1; i <= 16; i++) step_a("b2b f1", 1'b1, 8'(i), 1'b0);
      for (int i = 101; i <= 116; i++) begin
         step_a("b2b f2", 1'b1, 8'(i), 1'b0);
         if (i == 111)
            chk("b2b f2 first win", 216'(bus_a.win_dout),
                216'(pack9(101, 102, 103, 105, 106, 107, 109, 110, 111)));
      end
      step_a("b2b tail", 1'b0, 8'd0, 1'b0);
      chk("b2b nwin", 216'(n_win), 216'(8));
      chk("b2b nend", 216'(n_end), 216'(2));

      // Mid-frame reset after pixel 7
      for (int i = 1; i <= 7; i++) step_a("pre rst", 1'b1, 8'(i), 1'b0);
      @(negedge clk);
      bus_a.din_vld = 1'b0;
      rst = 1'b1;
      #1;
      chk("async rst vld", 216'(bus_a.win_vld), 216'(0));
      chk("async rst end", 216'(bus_a.win_end), 216'(0));
      chk("async rst dout", 216'(bus_a.win_dout), 216'(0));
      @(negedge clk);
      rst = 1'b0;
      mr = 0; mc = 0; m_dout = '0;
      n_win = 0; n_end = 0;
      for (int i = 1; i <= 16; i++) begin
         step_a("post rst", 1'b1, 8'(i), 1'b0);
         if (i == 11)
            chk("post rst first win", 216'(bus_a.win_dout), 216'(tbl[10].win));
      end
      step_a("post rst tail", 1'b0, 8'd0, 1'b0);
      chk("post rst nwin", 216'(n_win), 216'(4));
      chk("post rst nend", 216'(n_end), 216'(1));

      // clr together with din_vld on pixel 9
      for (int i = 1; i <= 8; i++) step_a("pre clr", 1'b1, 8'(i), 1'b0);
      step_a("clr", 1'b1, 8'd9, 1'b1);
      n_win = 0; n_end = 0;
      for (int i = 1; i <= 16; i++) begin
         step_a("post clr", 1'b1, 8'(i), 1'b0);
         if (i == 16)
            chk("post clr last win", 216'(bus_a.win_dout), 216'(tbl[15].win));
      end
      step_a("post clr tail", 1'b0, 8'd0, 1'b0);
      chk("post clr nwin", 216'(n_win), 216'(4));
      chk("post clr nend", 216'(n_end), 216'(1));

      // Default-parameter 34x34 random frame
      n_win = 0; n_end = 0;
      for (int r = 0; r < 34; r++) begin
         for (int c = 0; c < 34; c++) begin
            logic ev;
            @(negedge clk);
            bus_b.din_vld = 1'b1;
            bus_b.din     = 24'($urandom);
            imgb[r][c]    = bus_b.din;
            @(posedge clk);
            #1;
            ev = (r >= 2) && (c >= 2);
            chk($sformatf("big vld r%0d c%0d", r, c), 216'(bus_b.win_vld), 216'(ev));
            chk($sformatf("big end r%0d c%0d", r, c), 216'(bus_b.win_end),
                216'((r == 33) && (c == 33)));
            if (ev) begin
               for (int wr = 0; wr < 3; wr++)
                  for (int wc = 0; wc < 3; wc++)
                     bw[(3*wr+wc)*24 +: 24] = imgb[r-2+wr][c-2+wc];
               chk($sformatf("big dout r%0d c%0d", r, c), bus_b.win_dout, bw);
            end
            if (bus_b.win_vld) n_win++;
            if (bus_b.win_end) n_end++;
         end
      end
      @(negedge clk);
      bus_b.din_vld = 1'b0;
      @(posedge clk);
      #1;
      chk("big tail vld", 216'(bus_b.win_vld), 216'(0));
      chk("big nwin", 216'(n_win), 216'(1024));
      chk("big nend", 216'(n_end), 216'(1));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
